// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP inference datapath.
// Holds default widths, the writeback FSM state enum and saturation limits.
package mlp_pkg;

    localparam int ACC_W_D  = 32;
    localparam int DATA_W_D = 16;
    localparam int FRAC_W_D = 8;

    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint SAT_HI = sat_hi(DATA_W_D);
    localparam longint SAT_LO = sat_lo(DATA_W_D);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } wb_state_e;

endpackage

// File: rtl/fixed_requant.sv
// Combinational requantizer: round-half-up shift of a Q.(2F) sum to Q.F,
// saturation to DATA_W and optional ReLU.
// Ports: sum (ACC_W+1 signed), relu, act (DATA_W), sat (saturation flag).
module fixed_requant
    import mlp_pkg::*;
#(
    parameter int     ACC_W  = ACC_W_D,
    parameter int     DATA_W = DATA_W_D,
    parameter int     FRAC_W = FRAC_W_D,
    parameter longint HI     = SAT_HI,
    parameter longint LO     = SAT_LO
) (
    input  logic signed [ACC_W:0]    sum,
    input  logic                     relu,
    output logic        [DATA_W-1:0] act,
    output logic                     sat
);

    // One extra bit so adding the rounding half can never overflow.
    localparam int RW = ACC_W + 2;

    localparam logic signed [RW-1:0] HALF =
        {{(RW - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};
    localparam logic signed [RW-1:0] HI_V = RW'(HI);
    localparam logic signed [RW-1:0] LO_V = RW'(LO);

    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] r;

    always_comb begin
        rnd = {sum[ACC_W], sum} + HALF;
        r   = rnd >>> FRAC_W;
        sat = 1'b0;
        act = r[DATA_W-1:0];
        if (r > HI_V) begin
            act = HI_V[DATA_W-1:0];
            sat = 1'b1;
        end else if (r < LO_V) begin
            act = LO_V[DATA_W-1:0];
            sat = 1'b1;
        end
        if (relu && act[DATA_W-1]) begin
            act = '0;
        end
    end

endmodule

// File: rtl/layer_writeback.sv
// Layer writeback: bias add, requantize, saturate, ReLU, SRAM write, argmax.
// Ports: clk, reset (async low), start, last_layer, acc_valid/acc_ready,
// acc_data, bias, out_we/out_addr/out_data, busy, done, class_idx,
// class_score; sat_count when LAYER_WRITEBACK_SAT_COUNT_EN is defined.
module layer_writeback
    import mlp_pkg::*;
#(
    parameter int ACC_W       = ACC_W_D,
    parameter int DATA_W      = DATA_W_D,
    parameter int FRAC_W      = FRAC_W_D,
    parameter int ADDR_W      = 10,
    parameter int NUM_NEURONS = 64,
    parameter int CLS_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              last_layer,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [ACC_W-1:0]  acc_data,
    input  logic [DATA_W-1:0] bias,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
`ifdef LAYER_WRITEBACK_SAT_COUNT_EN
    output logic [15:0]       sat_count,
`endif
    output logic [CLS_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score
);

    // Counters hold NUM_NEURONS itself, so they need one bit above ADDR_W.
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] NUM = CW'(NUM_NEURONS);

    wb_state_e state, state_n;

    logic [CW-1:0]     in_cnt;
    logic [CW-1:0]     wr_cnt;
    logic [CW-1:0]     wr_next;
    logic              last_q;
    logic              fire;

    logic              s1_valid;
    logic [ACC_W:0]    s1_sum;
    logic [ACC_W:0]    sum_c;
    logic [ACC_W:0]    bias_ext;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_sat;
    logic [DATA_W-1:0] act_c;
    logic              sat_c;

    assign acc_ready = (state == ST_RUN) && (in_cnt < NUM);
    assign fire      = acc_valid && acc_ready;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign out_we    = s2_valid;
    assign out_data  = s2_data;
    assign out_addr  = wr_cnt[ADDR_W-1:0];
    // Counts the write retiring this cycle so FLUSH can leave without a bubble.
    assign wr_next   = wr_cnt + CW'(out_we);

    assign bias_ext = {{(ACC_W + 1 - DATA_W){bias[DATA_W-1]}}, bias};
    assign sum_c    = {acc_data[ACC_W-1], acc_data} + (bias_ext << FRAC_W);

    fixed_requant #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .HI     (sat_hi(DATA_W)),
        .LO     (sat_lo(DATA_W))
    ) u_requant (
        .sum  (s1_sum),
        .relu (!last_q),
        .act  (act_c),
        .sat  (sat_c)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (fire && (in_cnt == NUM - 1'b1)) state_n = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!s1_valid && (wr_next == NUM)) state_n = ST_DONE;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt      <= '0;
            wr_cnt      <= '0;
            last_q      <= 1'b0;
            s1_valid    <= 1'b0;
            s1_sum      <= '0;
            s2_valid    <= 1'b0;
            s2_data     <= '0;
            s2_sat      <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
        end else begin
            s1_valid <= fire;
            if (fire) begin
                s1_sum <= sum_c;
                in_cnt <= in_cnt + 1'b1;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= act_c;
                s2_sat  <= sat_c;
            end
            if (out_we) begin
                wr_cnt <= wr_next;
                // Strict compare keeps the lowest index on ties.
                if (last_q && ((wr_cnt == '0) ||
                    ($signed(s2_data) > $signed(class_score)))) begin
                    class_idx   <= CLS_W'(wr_cnt);
                    class_score <= s2_data;
                end
            end
            if (state == ST_IDLE && start) begin
                in_cnt      <= '0;
                wr_cnt      <= '0;
                last_q      <= last_layer;
                class_idx   <= '0;
                class_score <= '0;
            end
        end
    end

`ifdef LAYER_WRITEBACK_SAT_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (state == ST_IDLE && start) begin
            sat_count <= '0;
        end else if (out_we && s2_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_layer_writeback.sv
// Directed self-checking bench for layer_writeback with NUM_NEURONS = 4.
// Sat-count checks are compiled in with LAYER_WRITEBACK_SAT_COUNT_EN.
module tb_layer_writeback;

    localparam int NN = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        last_layer;
    logic        acc_valid;
    logic        acc_ready;
    logic [31:0] acc_data;
    logic [15:0] bias;
    logic        out_we;
    logic [9:0]  out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic [3:0]  class_idx;
    logic [15:0] class_score;
`ifdef LAYER_WRITEBACK_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    layer_writeback #(
        .ACC_W       (32),
        .DATA_W      (16),
        .FRAC_W      (8),
        .ADDR_W      (10),
        .NUM_NEURONS (NN),
        .CLS_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .last_layer  (last_layer),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_data    (acc_data),
        .bias        (bias),
        .out_we      (out_we),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
`ifdef LAYER_WRITEBACK_SAT_COUNT_EN
        .sat_count   (sat_count),
`endif
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_wr_cyc = 0;

    logic [31:0] acc_v [NN];
    logic [15:0] bias_v[NN];
    logic [15:0] exp_v [NN];
    int          wq_addr[$];
    logic [15:0] wq_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_we) begin
            wq_addr.push_back(int'(out_addr));
            wq_data.push_back(out_data);
            last_wr_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_pass(input bit last, input bit gap, input bit restart,
                            input int exp_idx, input logic [15:0] exp_score);
        int  i;
        int  k;
        int  t_last;
        bit  fire;
        wq_addr.delete();
        wq_data.delete();
        @(posedge clk); #1;
        start      = 1'b1;
        last_layer = last;
        @(posedge clk); #1;
        start      = 1'b0;
        last_layer = 1'b0;
        check("busy_run", busy, 1);
`ifdef LAYER_WRITEBACK_SAT_COUNT_EN
        check("sat_clr", sat_count, 0);
`endif
        i = 0;
        k = 0;
        t_last = 0;
        while (i < NN && k < 40) begin
            acc_valid = gap ? k[0] : 1'b1;
            acc_data  = acc_v[i];
            bias      = bias_v[i];
            start     = restart && (i == 1);
            last_layer = restart && (i == 1) && !last;
            fire = acc_valid && acc_ready;
            if (fire) t_last = cyc;
            @(posedge clk); #1;
            if (fire) i++;
            k++;
        end
        acc_valid  = 1'b0;
        start      = 1'b0;
        last_layer = 1'b0;
        check("beats", i, NN);
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("done", done, 1);
        check("done_lat", cyc - t_last, 3);
        check("wr_lat", last_wr_cyc - t_last, 2);
        check("cls_idx", class_idx, exp_idx);
        check("cls_score", class_score, exp_score);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("idle", busy, 0);
        check("n_wr", wq_data.size(), NN);
        for (int j = 0; j < NN && j < wq_data.size(); j++) begin
            check($sformatf("addr%0d", j), wq_addr[j], j);
            check($sformatf("data%0d", j), wq_data[j], exp_v[j]);
        end
    endtask

    task automatic set_vec(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3,
                           input logic [15:0] b0,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        acc_v[0] = a0; acc_v[1] = a1; acc_v[2] = a2; acc_v[3] = a3;
        bias_v[0] = b0; bias_v[1] = 16'h0; bias_v[2] = 16'h0; bias_v[3] = 16'h0;
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        last_layer = 1'b0;
        acc_valid  = 1'b0;
        acc_data   = '0;
        bias       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", out_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", acc_ready, 0);
        check("rst_idx", class_idx, 0);
        check("rst_score", class_score, 0);
        check("rst_data", out_data, 0);
        reset = 1'b1;

        // acc_valid outside RUN is ignored
        acc_valid = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", acc_ready, 0);
        acc_valid = 1'b0;

        // hidden layer: ReLU on, argmax held at 0
        set_vec(32'd65536, -32'sd65536, 32'd128, 32'h7FFFFFFF, 16'h0,
                16'd256, 16'd0, 16'd1, 16'd32767);
        run_pass(1'b0, 1'b0, 1'b0, 0, 16'd0);
`ifdef LAYER_WRITEBACK_SAT_COUNT_EN
        check("sat_hid", sat_count, 1);
`endif

        // last layer: negative kept, argmax = 3
        set_vec(32'd65536, -32'sd65536, 32'd128, 32'h7FFFFFFF, 16'h0,
                16'd256, 16'hFF00, 16'd1, 16'd32767);
        run_pass(1'b1, 1'b0, 1'b0, 3, 16'd32767);

        // bias path and negative saturation
        set_vec(32'd0, 32'h80000000, 32'd0, 32'd0, 16'h0180,
                16'h0180, 16'h8000, 16'h0, 16'h0);
        run_pass(1'b1, 1'b0, 1'b0, 0, 16'h0180);

        // two saturating beats
        set_vec(32'h7FFFFFFF, 32'd0, 32'h80000000, 32'd0, 16'h0,
                16'h7FFF, 16'h0, 16'h8000, 16'h0);
        run_pass(1'b1, 1'b0, 1'b0, 0, 16'h7FFF);
`ifdef LAYER_WRITEBACK_SAT_COUNT_EN
        check("sat_two", sat_count, 2);
`endif

        // tie {5,9,9,2}: lowest index wins, streamed then gapped
        set_vec(32'd1280, 32'd2304, 32'd2304, 32'd512, 16'h0,
                16'd5, 16'd9, 16'd9, 16'd2);
        run_pass(1'b1, 1'b0, 1'b0, 1, 16'd9);
        run_pass(1'b1, 1'b1, 1'b0, 1, 16'd9);

        // start pulsed mid-RUN is ignored
        run_pass(1'b1, 1'b0, 1'b1, 1, 16'd9);

        // reset dropped during beat 2 abandons the pass
        wq_data.delete();
        wq_addr.delete();
        @(posedge clk); #1;
        start = 1'b1;
        last_layer = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc_valid = 1'b1;
        acc_data = acc_v[0];
        @(posedge clk); #1;
        acc_data = acc_v[1];
        #2;
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_we", out_we, 0);
        check("mid_ready", acc_ready, 0);
        acc_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_nwr", wq_data.size(), 0);
        check("mid_idx", class_idx, 0);
        reset = 1'b1;

        set_vec(32'd65536, -32'sd65536, 32'd128, 32'h7FFFFFFF, 16'h0,
                16'd256, 16'd0, 16'd1, 16'd32767);
        run_pass(1'b0, 1'b0, 1'b0, 0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
